// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with optional parity
//
// Purpose: serialises one DATA_BITS-wide word per frame as start bit, data
//   bits LSB first, an optional parity bit and STOP_BITS stop bits. Each bit
//   is held for CYCLES_PER_BIT clocks.
// Build option: define UART_TX_PARITY_EN to build the parity bit and the
//   PARITY state; without it parity_mode is ignored and no parity is sent.
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   in          in   DATA_BITS word to send, latched on accept
//   send        in   transmit request, level-sampled while idle
//   parity_mode in   00 none, 01 even, 10 odd, 11 none; latched on accept
//   tx          out  serial line, registered, idle high
//   busy        out  high while a frame is in progress
//   done        out  one-cycle pulse in the first idle cycle after a frame
module uart_tx_cfg #(
  parameter int CYCLES_PER_BIT = 104,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in,
  input  logic                 send,
  input  logic [1:0]           parity_mode,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,S_PARITY = 3'd4
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
`else
  logic                 unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // tx_d is the line level for the state being entered, so the registered
  // tx lines up with the state register without any combinational path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (send) begin
          state_d   = S_START;
          shreg_d   = in;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_d = (^in) ^ (parity_mode == 2'b10);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = S_STOP;
            tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end
`endif
          end else begin
            idx_d   = idx_q + IW'(1);
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          // idx is reused to count stop bits
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_a = '0;
  logic       send_a = 1'b0;
  logic [1:0] pm_a = 2'b00;
  logic       tx_a, busy_a, done_a;
  logic [4:0] in_b = '0;
  logic       send_b = 1'b0;
  logic [1:0] pm_b = 2'b00;
  logic       tx_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CYCLES_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .send(send_a), .parity_mode(pm_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_cfg #(.CYCLES_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .send(send_b), .parity_mode(pm_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Starts a frame (accepted on the next posedge, cycle 0)
  // and checks tx/busy/done on every cycle through the done cycle; returns at
  // the negedge of the done cycle. par < 0 means no parity bit.
  task automatic frame(input string tag, input int sel, input logic [8:0] data,
                       input int nd, input int par, input int nstop, input bit hold);
    int nbits, len, k;
    logic t, b, d, e;
    nbits = 1 + nd + ((par >= 0) ? 1 : 0) + nstop;
    len   = nbits * 4;
    if (sel == 0) begin in_a = data[7:0]; send_a = 1'b1; end
    else          begin in_b = data[4:0]; send_b = 1'b1; end
    @(posedge clk);
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (sel == 0) begin t = tx_a; b = busy_a; d = done_a; end
      else          begin t = tx_b; b = busy_b; d = done_b; end
      k = (c - 1) / 4;
      if (c > len)                    e = 1'b1;
      else if (k == 0)                e = 1'b0;
      else if (k <= nd)               e = data[k-1];
      else if (par >= 0 && k == nd+1) e = par[0];
      else                            e = 1'b1;
      chk($sformatf("%s tx c%0d", tag, c), {31'b0, t}, {31'b0, e});
      chk($sformatf("%s busy c%0d", tag, c), {31'b0, b}, {31'b0, c <= len});
      chk($sformatf("%s done c%0d", tag, c), {31'b0, d}, {31'b0, c == len + 1});
      if (!hold) begin
        // send is dropped after accept; a mid-frame pulse with new data and
        // parity mode must change nothing
        if (sel == 0) begin
          send_a = (c == 10);
          if (c == 10) begin in_a = ~data[7:0]; pm_a = ~pm_a; end
        end else begin
          send_b = (c == 10);
          if (c == 10) in_b = ~data[4:0];
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst tx_a", {31'b0, tx_a}, 32'd1);
    chk("rst busy_a", {31'b0, busy_a}, 32'd0);
    chk("rst done_a", {31'b0, done_a}, 32'd0);
    chk("rst tx_b", {31'b0, tx_b}, 32'd1);
    chk("rst busy_b", {31'b0, busy_b}, 32'd0);
    rst = 1'b0;

    // basic frame 0xA5, then other patterns
    pm_a = 2'b00;
    frame("a5", 0, 9'h0A5, 8, -1, 1, 1'b0);
    pm_a = 2'b00;
    frame("00", 0, 9'h000, 8, -1, 1, 1'b0);
    pm_a = 2'b00;
    frame("ff", 0, 9'h0FF, 8, -1, 1, 1'b0);
    pm_a = 2'b00;
    frame("3c", 0, 9'h03C, 8, -1, 1, 1'b0);

`ifdef UART_TX_PARITY_EN
    pm_a = 2'b10;
    frame("odd03", 0, 9'h003, 8, 1, 1, 1'b0);
    pm_a = 2'b01;
    frame("even03", 0, 9'h003, 8, 0, 1, 1'b0);
    pm_a = 2'b01;
    frame("even07", 0, 9'h007, 8, 1, 1, 1'b0);
    pm_a = 2'b11;
    frame("pm11", 0, 9'h0A5, 8, -1, 1, 1'b0);
`else
    pm_a = 2'b01;
    frame("nopar", 0, 9'h0A5, 8, -1, 1, 1'b0);
`endif

    // two stop bits, five data bits
    frame("b1f", 1, 9'h01F, 5, -1, 2, 1'b0);
    frame("b0a", 1, 9'h00A, 5, -1, 2, 1'b0);

    // send held high: second frame accepted at the end of the done cycle
    pm_a = 2'b00;
    frame("b2b1", 0, 9'h0C3, 8, -1, 1, 1'b1);
    frame("b2b2", 0, 9'h05A, 8, -1, 1, 1'b1);
    send_a = 1'b0;
    @(negedge clk);
    chk("b2b idle busy", {31'b0, busy_a}, 32'd0);

    // reset mid-frame
    in_a = 8'h81;
    send_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      send_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort tx", {31'b0, tx_a}, 32'd1);
    chk("abort busy", {31'b0, busy_a}, 32'd0);
    chk("abort done", {31'b0, done_a}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort quiet done", {31'b0, done_a}, 32'd0);
      chk("abort quiet tx", {31'b0, tx_a}, 32'd1);
    end
    frame("after", 0, 9'h096, 8, -1, 1, 1'b0);

    // reset wins over send
    rst = 1'b1;
    send_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_a = 1'b0;
    chk("rst prio busy", {31'b0, busy_a}, 32'd0);
    @(negedge clk);
    chk("rst prio busy2", {31'b0, busy_a}, 32'd0);
    chk("rst prio tx", {31'b0, tx_a}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
